int_seq: RTL and testbench
==========================

// Module: int_seq
// PURPOSE
//  Interrupt/reset entry sequencer beside fsm. Samples NMI/IRQ at opcode boundaries (SYNC).
//  Runs the 7-cycle entry: push PCH, PCL, P; fetch vector lo/hi. BRK uses the same sequence.
//  While BUSY it owns the address bus, stack-write strobes and PC-load strobes.
//  fsm is held off via BUSY.
// PARAMETERS
//  VEC_NMI   16'hFFFA  NMI vector address (lo byte; hi = +1)
//  VEC_RES   16'hFFFC  reset vector address
//  VEC_IRQ   16'hFFFE  IRQ/BRK vector address
//  SP_PAGE   8'h01     stack page, drives ADR[15:8] during pushes
// PORTS
//  CLK     in   1   system clock, rising edge
//  RST     in   1   asynchronous, active-high reset
//  RDY     in   1   1 = advance; 0 = freeze state and all registered outputs
//  SYNC    in   1   opcode-fetch cycle flag from fsm
//  BRK     in   1   decoder: BRK opcode decoded (cycle after SYNC)
//  NMI     in   1   NMI request, active-high, rising-edge sensitive
//  IRQ     in   1   IRQ request, active-high, level sensitive
//  I_FLAG  in   1   status I bit (1 = IRQ masked)
//  SP      in   8   current stack pointer
//  ADR     out  16  address driven while BUSY
//  WR      out  1   stack write strobe
//  SPDEC   out  1   decrement SP this cycle
//  DSEL    out  2   data source: 0 = PCH, 1 = PCL, 2 = P
//  BFLAG   out  1   B bit value merged into pushed P
//  SET_I   out  1   set I flag (asserted in VLO)
//  LD_PCL  out  1   load PCL from data bus
//  LD_PCH  out  1   load PCH from data bus
//  INJ     out  1   force BRK (00) into IR; pending interrupt accepted
//  BUSY    out  1   sequencer owns bus; fsm stalls
// BEHAVIOUR
//  - States: IDLE, PCH, PCL, PSW, VLO, VHI; 3-bit encoding in int_seq_pkg.
//  - RST: state = PCH, src = RES. BUSY = 1; all other outputs 0. nmi_pend = 0, nmi_q = 0.
//  - NMI edge: nmi_q <= NMI each cycle. NMI & ~nmi_q sets nmi_pend.
//    nmi_pend clears on the VLO cycle when src = NMI; set has priority over clear.
//  - Accept: in IDLE, a SYNC cycle with (nmi_pend | IRQ & ~I_FLAG) registers INJ = 1 for the next cycle.
//    Source latched with priority NMI > IRQ.
//  - Start: IDLE -> PCH on the cycle after SYNC if INJ | BRK.
//    BRK without INJ sets src = BRK, BFLAG = 1; otherwise BFLAG = 0.
//  - PCH/PCL/PSW: ADR = {SP_PAGE, SP}, SPDEC = 1, DSEL = 0/1/2.
//    WR = 1 except src = RES: dummy cycle, WR = 0, SPDEC still 1.
//  - VLO: ADR = vec, LD_PCL = 1, SET_I = 1. VHI: ADR = vec + 1, LD_PCH = 1, then -> IDLE.
//  - Latency: accept SYNC -> first push = 2 cycles; PCH -> IDLE = 5 cycles.
//    BUSY is high in PCH..VHI.
//  - RDY = 0: no state, pending or output change. NMI edge detection still runs.
//  - RST mid-sequence: immediately restarts as reset sequence; in-flight source is lost.
//  - IRQ deasserted after accept: sequence still completes (no abort).
//  - NMI during own sequence: becomes pending again; taken at the next SYNC.
// CONFIGURATION
//  INT_SEQ_NMI_HIJACK_EN defined: a pending NMI seen in PCH..PSW of an IRQ/BRK sequence
//  switches vec to VEC_NMI at VLO. BFLAG already pushed is unchanged; nmi_pend clears.
//  Undefined: vector fixed at start; NMI stays pending until the next SYNC.
// STRUCTURE
//  int_seq_pkg: state encoding, src encoding (RES/NMI/IRQ/BRK), DSEL codes.
//  int_seq_nmi_det sub-module: NMI edge detector + pending latch, with clear and RDY qualify.
//  Vector mux and output decode are combinational from the registered state and src.
// TESTING
//  1. RST pulse, RDY = 1 -> 5 BUSY cycles, WR never 1, SPDEC x3;
//     ADR FFFC then FFFD with LD_PCL then LD_PCH; IDLE after.
//  2. IRQ = 1, I_FLAG = 0, SYNC, SP = 8'hFD -> INJ; ADR 01FD/01FC/01FB with WR, DSEL 0/1/2;
//     BFLAG = 0; ADR FFFE/FFFF.
//  3. BRK at cycle after SYNC, no IRQ -> same sequence with BFLAG = 1, vector FFFE.
//  4. NMI 0->1 held high, IRQ also high -> NMI taken first (FFFA).
//     No retrigger while NMI stays high; IRQ taken next SYNC.
//  5. RDY = 0 for 3 cycles in PCL -> ADR/WR/DSEL frozen; sequence resumes, total length +3.
//  6. HIJACK_EN: NMI rises during PCL of BRK -> VLO ADR = FFFA, BFLAG = 1;
//     without macro -> FFFE, then NMI at next SYNC.

Source files
------------

// File: rtl/int_seq_pkg.sv
// Shared encodings for the interrupt/reset entry sequencer.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package int_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PCH  = 3'd1,
    ST_PCL  = 3'd2,
    ST_PSW  = 3'd3,
    ST_VLO  = 3'd4,
    ST_VHI  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SRC_RES = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } src_t;

  localparam logic [1:0] DSEL_PCH = 2'd0;
  localparam logic [1:0] DSEL_PCL = 2'd1;
  localparam logic [1:0] DSEL_PSW = 2'd2;

  localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
  localparam logic [15:0] VEC_RES_DEF = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;
  localparam logic [7:0]  SP_PAGE_DEF = 8'h01;

  // Vector low-byte address for a given entry source; BRK shares the IRQ vector.
  function automatic logic [15:0] vec_sel(input src_t src, input logic [15:0] nmi_v,
                                          input logic [15:0] res_v, input logic [15:0] irq_v);
    logic [15:0] v;
    v = irq_v;
    case (src)
      SRC_NMI: v = nmi_v;
      SRC_RES: v = res_v;
      default: v = irq_v;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/int_seq_nmi_det.sv
// NMI rising-edge detector with pending latch (set wins over clear).
// Latency: edge seen in cycle N -> pend high in cycle N+1 (when rdy).
// Backpressure: rdy=0 freezes pend; edges seen meanwhile are held and folded in once rdy returns.
// Ports: clk, rst (async, active-high), rdy, nmi (request), clr (consume pending), pend (pending NMI).
module int_seq_nmi_det (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic nmi,
  input  logic clr,
  output logic pend
);

  logic nmi_q;
  logic edge_hold;
  logic rise;

  assign rise = nmi & ~nmi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_q     <= 1'b0;
      edge_hold <= 1'b0;
      pend      <= 1'b0;
    end else begin
      // The edge sampler keeps running while stalled so a short pulse is not lost.
      nmi_q <= nmi;
      if (rdy) begin
        edge_hold <= 1'b0;
        if (rise || edge_hold) begin
          pend <= 1'b1;
        end else if (clr) begin
          pend <= 1'b0;
        end
      end else if (rise) begin
        edge_hold <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_seq.sv
// Interrupt/reset/BRK entry sequencer: pushes PCH, PCL, P then fetches the vector lo/hi.
// Latency: accepting SYNC -> first push 2 cycles; PCH -> IDLE 5 cycles; busy high PCH..VHI.
// Backpressure: rdy=0 freezes state, pending NMI and all outputs; busy stalls the main fsm.
// Ports: clk, rst (async, active-high), rdy, sync, brk, nmi, irq, i_flag, sp[7:0] in;
//        adr[15:0], wr, spdec, dsel[1:0], bflag, set_i, ld_pcl, ld_pch, inj, busy out.
// Build option: define INT_SEQ_NMI_HIJACK_EN to let a pending NMI redirect an IRQ/BRK entry
// to the NMI vector if it is seen during the pushes.
module int_seq
  import int_seq_pkg::*;
#(
  parameter logic [15:0] VEC_NMI = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RES = VEC_RES_DEF,
  parameter logic [15:0] VEC_IRQ = VEC_IRQ_DEF,
  parameter logic [7:0]  SP_PAGE = SP_PAGE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        sync,
  input  logic        brk,
  input  logic        nmi,
  input  logic        irq,
  input  logic        i_flag,
  input  logic [7:0]  sp,
  output logic [15:0] adr,
  output logic        wr,
  output logic        spdec,
  output logic [1:0]  dsel,
  output logic        bflag,
  output logic        set_i,
  output logic        ld_pcl,
  output logic        ld_pch,
  output logic        inj,
  output logic        busy
);

  state_t      state_q, state_d;
  src_t        src_q, src_d;
  logic        bflag_q, bflag_d;
  logic        inj_q, inj_d;
  logic        sync_q;
  logic        nmi_pend;
  logic        nmi_clr;
  logic        start;
  logic [15:0] vec_base;

  int_seq_nmi_det u_nmi_det (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .nmi  (nmi),
    .clr  (nmi_clr),
    .pend (nmi_pend)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Reset itself is an entry sequence: come out of reset already in PCH.
      state_q <= ST_PCH;
      src_q   <= SRC_RES;
      bflag_q <= 1'b0;
      inj_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      src_q   <= src_d;
      bflag_q <= bflag_d;
      inj_q   <= inj_d;
      sync_q  <= sync;
    end
  end

  assign vec_base = vec_sel(src_q, VEC_NMI, VEC_RES, VEC_IRQ);
  assign nmi_clr  = (state_q == ST_VLO) && (src_q == SRC_NMI);
  assign start    = (state_q == ST_IDLE) && sync_q && (inj_q || brk);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    bflag_d = bflag_q;
    inj_d   = 1'b0;
    adr     = 16'h0000;
    wr      = 1'b0;
    spdec   = 1'b0;
    dsel    = DSEL_PCH;
    set_i   = 1'b0;
    ld_pcl  = 1'b0;
    ld_pch  = 1'b0;
    busy    = (state_q != ST_IDLE);
    bflag   = (state_q != ST_IDLE) && bflag_q;
    inj     = inj_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PCH;
          // An accepted interrupt outranks a BRK decoded in the same slot.
          if (inj_q) begin
            bflag_d = 1'b0;
          end else begin
            src_d   = SRC_BRK;
            bflag_d = 1'b1;
          end
        end else if (sync && !inj_q && (nmi_pend || (irq && !i_flag))) begin
          inj_d = 1'b1;
          src_d = nmi_pend ? SRC_NMI : SRC_IRQ;
        end
      end
      ST_PCH, ST_PCL, ST_PSW: begin
        adr   = {SP_PAGE, sp};
        spdec = 1'b1;
        // Reset walks the stack pointer down without writing (dummy pushes).
        wr    = (src_q != SRC_RES);
        case (state_q)
          ST_PCH:  begin dsel = DSEL_PCH; state_d = ST_PCL; end
          ST_PCL:  begin dsel = DSEL_PCL; state_d = ST_PSW; end
          default: begin dsel = DSEL_PSW; state_d = ST_VLO; end
        endcase
`ifdef INT_SEQ_NMI_HIJACK_EN
        // Redirect to the NMI vector; the B bit already chosen stays as pushed.
        if (nmi_pend && (src_q == SRC_IRQ || src_q == SRC_BRK)) begin
          src_d = SRC_NMI;
        end
`endif
      end
      ST_VLO: begin
        adr     = vec_base;
        ld_pcl  = 1'b1;
        set_i   = 1'b1;
        state_d = ST_VHI;
      end
      ST_VHI: begin
        adr     = vec_base + 16'd1;
        ld_pch  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // While reset is held only busy is shown; the sequence starts on release.
    if (rst) begin
      adr    = 16'h0000;
      wr     = 1'b0;
      spdec  = 1'b0;
      dsel   = DSEL_PCH;
      set_i  = 1'b0;
      ld_pcl = 1'b0;
      ld_pch = 1'b0;
      bflag  = 1'b0;
      inj    = 1'b0;
      busy   = 1'b1;
    end
  end

endmodule

// File: tb/tb_int_seq.sv
// Bench for int_seq: per-cycle expected output records go through a scoreboard queue.
// Latency: n/a.
// Backpressure: exercises rdy stalls mid-sequence.
module tb_int_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        sync = 1'b0;
  logic        brk = 1'b0;
  logic        nmi = 1'b0;
  logic        irq = 1'b0;
  logic        i_flag = 1'b0;
  logic [7:0]  sp = 8'hFF;
  logic [15:0] adr;
  logic        wr, spdec, bflag, set_i, ld_pcl, ld_pch, inj, busy;
  logic [1:0]  dsel;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] adr;
    logic        wr;
    logic        spdec;
    logic [1:0]  dsel;
    logic        bflag;
    logic        set_i;
    logic        ld_pcl;
    logic        ld_pch;
    logic        inj;
    logic        busy;
  } out_t;

  typedef struct {
    logic        irq;
    logic        i_flag;
    logic        brk;
    logic [7:0]  sp;
    logic        acc;
    logic        start;
    logic        bf;
  } vec_t;

  out_t exp_q[$];
  vec_t tbl[6];

  int_seq dut (
    .clk(clk), .rst(rst), .rdy(rdy), .sync(sync), .brk(brk), .nmi(nmi), .irq(irq),
    .i_flag(i_flag), .sp(sp), .adr(adr), .wr(wr), .spdec(spdec), .dsel(dsel),
    .bflag(bflag), .set_i(set_i), .ld_pcl(ld_pcl), .ld_pch(ld_pch), .inj(inj), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic out_t idle_v();
    out_t o;
    o = '0;
    return o;
  endfunction

  function automatic out_t rst_v();
    out_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t inj_v();
    out_t o;
    o = '0;
    o.inj = 1'b1;
    return o;
  endfunction

  // Expected outputs for phase k (0..4 = PCH, PCL, PSW, VLO, VHI) of an entry sequence.
  function automatic out_t seq_v(input int k, input logic [15:0] vec, input logic w,
                                 input logic bf, input logic [7:0] s);
    out_t o;
    o = '0;
    o.busy  = 1'b1;
    o.bflag = bf;
    case (k)
      0, 1, 2: begin
        o.adr   = {8'h01, s};
        o.wr    = w;
        o.spdec = 1'b1;
        o.dsel  = 2'(k);
      end
      3: begin
        o.adr    = vec;
        o.ld_pcl = 1'b1;
        o.set_i  = 1'b1;
      end
      default: begin
        o.adr    = vec + 16'd1;
        o.ld_pch = 1'b1;
      end
    endcase
    return o;
  endfunction

  // Called at posedge+1 with this cycle's inputs set; compares, then advances one cycle.
  // The bench plays the fsm's part of moving SP down when a push is acknowledged.
  task automatic chk(input out_t e, input string nm);
    out_t a;
    out_t x;
    logic r;
    exp_q.push_back(e);
    #1;
    a = {adr, wr, spdec, dsel, bflag, set_i, ld_pcl, ld_pch, inj, busy};
    x = exp_q.pop_front();
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s t=%0t got adr=%h wr=%b spdec=%b dsel=%0d bflag=%b set_i=%b ld_pcl=%b ld_pch=%b inj=%b busy=%b | want adr=%h wr=%b spdec=%b dsel=%0d bflag=%b set_i=%b ld_pcl=%b ld_pch=%b inj=%b busy=%b",
               nm, $time, a.adr, a.wr, a.spdec, a.dsel, a.bflag, a.set_i, a.ld_pcl, a.ld_pch, a.inj, a.busy,
               x.adr, x.wr, x.spdec, x.dsel, x.bflag, x.set_i, x.ld_pcl, x.ld_pch, x.inj, x.busy);
    end
    r = rdy;
    @(posedge clk);
    #1;
    if (x.spdec && r) sp = sp - 8'd1;
  endtask

  task automatic run_seq(input logic [15:0] vec, input logic w, input logic bf, input string nm);
    for (int k = 0; k < 5; k++) chk(seq_v(k, vec, w, bf, sp), nm);
  endtask

  initial begin
    tbl[0] = '{irq:1'b1, i_flag:1'b0, brk:1'b0, sp:8'hFD, acc:1'b1, start:1'b1, bf:1'b0};
    tbl[1] = '{irq:1'b0, i_flag:1'b0, brk:1'b1, sp:8'hF0, acc:1'b0, start:1'b1, bf:1'b1};
    tbl[2] = '{irq:1'b1, i_flag:1'b1, brk:1'b0, sp:8'h80, acc:1'b0, start:1'b0, bf:1'b0};
    tbl[3] = '{irq:1'b1, i_flag:1'b1, brk:1'b1, sp:8'h01, acc:1'b0, start:1'b1, bf:1'b1};
    tbl[4] = '{irq:1'b1, i_flag:1'b0, brk:1'b1, sp:8'h02, acc:1'b1, start:1'b1, bf:1'b0};
    tbl[5] = '{irq:1'b0, i_flag:1'b0, brk:1'b0, sp:8'h55, acc:1'b0, start:1'b0, bf:1'b0};

    // Reset: busy only while held, then a write-less entry through the reset vector.
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk(rst_v(), "rst_hold");
    chk(rst_v(), "rst_hold");
    rst = 1'b0;
    run_seq(16'hFFFC, 1'b0, 1'b0, "rst_seq");
    chk(idle_v(), "rst_idle");
    chk(idle_v(), "rst_idle");

    // Table: IRQ / BRK / masking combinations.
    for (int t = 0; t < 6; t++) begin
      sp = tbl[t].sp; irq = tbl[t].irq; i_flag = tbl[t].i_flag; sync = 1'b1;
      chk(idle_v(), "tbl_sync");
      sync = 1'b0; brk = tbl[t].brk;
      chk(tbl[t].acc ? inj_v() : idle_v(), "tbl_inj");
      brk = 1'b0;
      if (tbl[t].start) run_seq(16'hFFFE, 1'b1, tbl[t].bf, "tbl_seq");
      else for (int k = 0; k < 5; k++) chk(idle_v(), "tbl_noseq");
      chk(idle_v(), "tbl_post");
      irq = 1'b0; i_flag = 1'b0;
    end

    // NMI outranks IRQ; a held NMI does not retrigger; IRQ follows at the next SYNC.
    sp = 8'hFD; nmi = 1'b1; irq = 1'b1;
    chk(idle_v(), "nmi_edge");
    sync = 1'b1; chk(idle_v(), "nmi_sync");
    sync = 1'b0; chk(inj_v(), "nmi_inj");
    run_seq(16'hFFFA, 1'b1, 1'b0, "nmi_seq");
    chk(idle_v(), "nmi_post");
    sync = 1'b1; chk(idle_v(), "irq2_sync");
    sync = 1'b0; chk(inj_v(), "irq2_inj");
    run_seq(16'hFFFE, 1'b1, 1'b0, "irq2_seq");
    chk(idle_v(), "irq2_post");
    irq = 1'b0;
    sync = 1'b1; chk(idle_v(), "nmi_held_sync");
    sync = 1'b0; chk(idle_v(), "nmi_no_retrig");
    nmi = 1'b0;
    chk(idle_v(), "nmi_low");

    // rdy=0 for three PCL cycles; IRQ dropped after accept must not abort.
    sp = 8'hFD; irq = 1'b1; sync = 1'b1;
    chk(idle_v(), "rdy_sync");
    sync = 1'b0; chk(inj_v(), "rdy_inj");
    irq = 1'b0;
    chk(seq_v(0, 16'hFFFE, 1'b1, 1'b0, sp), "rdy_pch");
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) chk(seq_v(1, 16'hFFFE, 1'b1, 1'b0, sp), "rdy_frozen");
    rdy = 1'b1;
    for (int k = 1; k < 5; k++) chk(seq_v(k, 16'hFFFE, 1'b1, 1'b0, sp), "rdy_resume");
    chk(idle_v(), "rdy_post");

    // NMI rising during PCL of a BRK entry.
    sp = 8'hE0; sync = 1'b1;
    chk(idle_v(), "hj_sync");
    sync = 1'b0; brk = 1'b1;
    chk(idle_v(), "hj_brk");
    brk = 1'b0;
    chk(seq_v(0, 16'hFFFE, 1'b1, 1'b1, sp), "hj_pch");
    nmi = 1'b1;
    chk(seq_v(1, 16'hFFFE, 1'b1, 1'b1, sp), "hj_pcl");
    chk(seq_v(2, 16'hFFFE, 1'b1, 1'b1, sp), "hj_psw");
`ifdef INT_SEQ_NMI_HIJACK_EN
    chk(seq_v(3, 16'hFFFA, 1'b1, 1'b1, sp), "hj_vlo");
    chk(seq_v(4, 16'hFFFA, 1'b1, 1'b1, sp), "hj_vhi");
    chk(idle_v(), "hj_post");
    sync = 1'b1; chk(idle_v(), "hj_sync2");
    sync = 1'b0; chk(idle_v(), "hj_no_pend");
`else
    chk(seq_v(3, 16'hFFFE, 1'b1, 1'b1, sp), "hj_vlo");
    chk(seq_v(4, 16'hFFFE, 1'b1, 1'b1, sp), "hj_vhi");
    chk(idle_v(), "hj_post");
    sync = 1'b1; chk(idle_v(), "hj_sync2");
    sync = 1'b0; chk(inj_v(), "hj_nmi_inj");
    run_seq(16'hFFFA, 1'b1, 1'b0, "hj_nmi_seq");
    chk(idle_v(), "hj_nmi_post");
`endif
    nmi = 1'b0;
    chk(idle_v(), "hj_end");

    // Reset arriving mid-sequence restarts as a reset entry.
    sp = 8'hC0; irq = 1'b1; sync = 1'b1;
    chk(idle_v(), "rm_sync");
    sync = 1'b0; chk(inj_v(), "rm_inj");
    irq = 1'b0;
    chk(seq_v(0, 16'hFFFE, 1'b1, 1'b0, sp), "rm_pch");
    chk(seq_v(1, 16'hFFFE, 1'b1, 1'b0, sp), "rm_pcl");
    rst = 1'b1;
    chk(rst_v(), "rm_hold");
    chk(rst_v(), "rm_hold");
    rst = 1'b0;
    run_seq(16'hFFFC, 1'b0, 1'b0, "rm_seq");
    chk(idle_v(), "rm_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
